idct4_seq: RTL and testbench
============================

IDCT4_SEQ -- requirements
Module: idct4_seq

Interface
REQ-001 SHALL have parameter SHIFT_1, default 7: first-stage (column) right-shift amount.
REQ-002 SHALL have parameter SHIFT_2, default 12: second-stage (row) right-shift amount.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: an input vector is offered.
REQ-006 SHALL have port in_ready, output, 1: the block can accept a vector this cycle.
REQ-007 SHALL have port stage_sel, input, 1: 0 selects SHIFT_1, 1 selects SHIFT_2; sampled at accept.
REQ-008 SHALL have ports d_in_0..d_in_3, input, 25 each, signed: coefficients x0..x3.
REQ-009 SHALL have port out_valid, output, 1: d_out holds a result.
REQ-010 SHALL have port out_ready, input, 1: the downstream consumer takes the result.
REQ-011 SHALL have port d_out, output, 25, signed: result y[out_idx].
REQ-012 SHALL have port out_idx, output, 2: index of the result, 0..3.
REQ-013 SHALL have port out_last, output, 1: asserted with out_idx==3.
REQ-014 SHALL have port busy, output, 1: the FSM is in BUSY.

Function
REQ-015 SHALL implement a 2-state FSM, IDLE and BUSY.
REQ-016 in_ready SHALL be 1 in IDLE and 0 in BUSY; in_valid during BUSY SHALL be ignored.
REQ-017 Accept SHALL occur when in_valid && in_ready.
  - On accept: latch x0..x3 and stage_sel, set idx=0, enter BUSY.
REQ-018 Results SHALL use the 4-point IDCT coefficients:
  - y0 = 64x0 + 83x1 + 64x2 + 36x3
  - y1 = 64x0 + 36x1 - 64x2 - 83x3
  - y2 = 64x0 - 36x1 - 64x2 + 83x3
  - y3 = 64x0 - 83x1 + 64x2 - 36x3
REQ-019 The sum SHALL be computed signed at 36 bits (no internal overflow).
  - S = selected shift; result = (sum + 2^(S-1)) >>> S, arithmetic shift.
  - The result SHALL be truncated to its low 25 bits.
REQ-020 The output register SHALL load when BUSY && (!out_valid || out_ready).
  - Loads d_out=y[idx], out_idx=idx, out_last=(idx==3), out_valid=1.
  - idx then increments.
REQ-021 Loading idx==3 SHALL return the FSM to IDLE.
REQ-022 When out_valid && out_ready && no new load occurs, out_valid SHALL clear next cycle.
REQ-023 While out_valid && !out_ready:
  - d_out, out_idx and out_last SHALL hold stable.
  - idx SHALL not advance; no result is lost or duplicated.
REQ-024 Latency without backpressure:
  - accept at cycle t -> y0 valid at t+1, y3 at t+4.
  - Throughput one vector per 5 cycles.
REQ-025 A new vector SHALL be acceptable in IDLE while y3 is still held in the output register.
  - Its y0 SHALL load only after y3 is consumed.
REQ-026 busy SHALL equal (state==BUSY).

Reset
REQ-027 On reset low, regardless of clk and mid-operation:
  - state=IDLE, idx=0.
  - out_valid=0, d_out=0, out_idx=0, out_last=0, busy=0.
  - latched x and stage_sel = 0.
REQ-028 After reset release, in_ready SHALL be 1 in the first cycle; partially output vectors SHALL not resume.

Verification
REQ-029 Bench SHALL cover the following directed scenarios:
  - x=(100,0,0,0), stage_sel=0, out_ready=1 -> d_out 50,50,50,50; out_idx 0..3; out_last only on idx 3; y0 one cycle after accept.
  - x=(0,100,0,0), stage_sel=0 -> 65, 28, -28, -65 (checks signed rounding).
  - x=(4096,0,0,0), stage_sel=1 -> 64,64,64,64; then x=(0,0,0,-4096) -> -36, 83, -83, 36.
  - out_ready held 0 for 3 cycles after y0 appears -> d_out/out_idx frozen at y0/0; after release, y1..y3 follow on consecutive cycles, 4 results total.
  - in_valid held 1 continuously with out_ready=1 -> in_ready pulses once per 5 cycles; each vector's 4 results are in order and unmixed.
  - reset driven low while idx==2 -> all outputs 0 immediately; after release, in_ready=1, no stale result appears, and the next vector outputs correctly.

Source files
------------

// File: rtl/idct4_seq.sv
// Sequential 4-point inverse DCT: accepts one coefficient vector, then emits
// y0..y3 one per cycle through a valid/ready output register with rounding shift.
//   state | meaning
//   IDLE  | waiting for an input vector; in_ready high
//   BUSY  | producing y[idx]; input side stalled
module idct4_seq #(
    parameter int SHIFT_1 = 7,
    parameter int SHIFT_2 = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               stage_sel,
    input  logic signed [24:0] d_in_0,
    input  logic signed [24:0] d_in_1,
    input  logic signed [24:0] d_in_2,
    input  logic signed [24:0] d_in_3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [24:0] d_out,
    output logic [1:0]         out_idx,
    output logic               out_last,
    output logic               busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic signed [35:0] RND_1 = 36'sd1 <<< (SHIFT_1 - 1);
    localparam logic signed [35:0] RND_2 = 36'sd1 <<< (SHIFT_2 - 1);

    state_t             state, state_nxt;
    logic [1:0]         idx;
    logic signed [24:0] x0, x1, x2, x3;
    logic               sel;
    logic               accept, load;
    logic signed [35:0] ex0, ex1, ex2, ex3;
    logic signed [35:0] sum, res;
    logic               unused_res_hi;

    assign in_ready = (state == IDLE);
    assign busy     = (state == BUSY);
    assign accept   = in_valid && in_ready;
    assign load     = (state == BUSY) && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (load && idx == 2'd3) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // 36-bit products and sum cannot overflow for 25-bit inputs and 7-bit coefficients
    always_comb begin
        ex0 = {{11{x0[24]}}, x0};
        ex1 = {{11{x1[24]}}, x1};
        ex2 = {{11{x2[24]}}, x2};
        ex3 = {{11{x3[24]}}, x3};
        sum = '0;
        case (idx)
            2'd0: sum = ex0 * 36'sd64 + ex1 * 36'sd83 + ex2 * 36'sd64 + ex3 * 36'sd36;
            2'd1: sum = ex0 * 36'sd64 + ex1 * 36'sd36 - ex2 * 36'sd64 - ex3 * 36'sd83;
            2'd2: sum = ex0 * 36'sd64 - ex1 * 36'sd36 - ex2 * 36'sd64 + ex3 * 36'sd83;
            default: sum = ex0 * 36'sd64 - ex1 * 36'sd83 + ex2 * 36'sd64 - ex3 * 36'sd36;
        endcase
        res = sel ? ((sum + RND_2) >>> SHIFT_2) : ((sum + RND_1) >>> SHIFT_1);
    end

    assign unused_res_hi = ^res[35:25];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= 2'd0;
            x0        <= '0;
            x1        <= '0;
            x2        <= '0;
            x3        <= '0;
            sel       <= 1'b0;
            out_valid <= 1'b0;
            d_out     <= '0;
            out_idx   <= 2'd0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                x0  <= d_in_0;
                x1  <= d_in_1;
                x2  <= d_in_2;
                x3  <= d_in_3;
                sel <= stage_sel;
                idx <= 2'd0;
            end
            // A held y3 can linger into IDLE; it clears once consumed
            if (load) begin
                d_out     <= res[24:0];
                out_idx   <= idx;
                out_last  <= (idx == 2'd3);
                out_valid <= 1'b1;
                idx       <= idx + 2'd1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_idct4_seq.sv
// Directed bench for idct4_seq: vector table plus backpressure, streaming
// and mid-vector reset sequences.
module tb_idct4_seq;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic               stage_sel;
    logic signed [24:0] d_in_0, d_in_1, d_in_2, d_in_3;
    logic               out_valid;
    logic               out_ready;
    logic signed [24:0] d_out;
    logic [1:0]         out_idx;
    logic               out_last;
    logic               busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    idct4_seq #(.SHIFT_1(7), .SHIFT_2(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .stage_sel (stage_sel),
        .d_in_0    (d_in_0),
        .d_in_1    (d_in_1),
        .d_in_2    (d_in_2),
        .d_in_3    (d_in_3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_out     (d_out),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    typedef struct {
        int x0, x1, x2, x3;
        bit sel;
        int y0, y1, y2, y3;
    } vec_t;

    vec_t tbl[7];

    function automatic int exp_y(input vec_t v, input int k);
        case (k)
            0:       return v.y0;
            1:       return v.y1;
            2:       return v.y2;
            default: return v.y3;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        d_in_0    = 25'(v.x0);
        d_in_1    = 25'(v.x1);
        d_in_2    = 25'(v.x2);
        d_in_3    = 25'(v.x3);
        stage_sel = v.sel;
    endtask

    // returns on the falling edge right after the accepting rising edge
    task automatic send(input vec_t v, input string tag);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        drive(v);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input vec_t v, input string tag);
        for (int k = 0; k < 4; k++) begin
            int w = 0;
            @(negedge clk);
            while (!out_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (k == 0) chk({tag, "_y0_latency"}, w, 0);
            chk($sformatf("%s_y%0d", tag, k), int'(d_out), exp_y(v, k));
            chk($sformatf("%s_idx%0d", tag, k), int'(out_idx), k);
            chk($sformatf("%s_last%0d", tag, k), int'(out_last), (k == 3) ? 1 : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t s[3];
        int   expq[$];
        int   nres, nacc, last;

        tbl[0] = '{100, 0, 0, 0, 1'b0, 50, 50, 50, 50};
        tbl[1] = '{0, 100, 0, 0, 1'b0, 65, 28, -28, -65};
        tbl[2] = '{4096, 0, 0, 0, 1'b1, 64, 64, 64, 64};
        tbl[3] = '{0, 0, 0, -4096, 1'b1, -36, 83, -83, 36};
        tbl[4] = '{1, 1, 1, 1, 1'b0, 2, 0, 0, 0};
        tbl[5] = '{16777215, 16777215, 16777215, 16777215, 1'b0,
                   -1179650, -6160384, 6160384, 1179648};
        tbl[6] = '{-100, 0, 0, 0, 1'b0, -50, -50, -50, -50};

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(tbl[0]);
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_d_out", int'(d_out), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        chk("rel_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 7; i++) begin
            send(tbl[i], $sformatf("v%0d", i));
            collect(tbl[i], $sformatf("v%0d", i));
        end
        @(negedge clk);
        chk("drain_out_valid", int'(out_valid), 0);

        // backpressure: y0 held for three cycles
        out_ready = 1'b0;
        send(tbl[1], "bp");
        @(negedge clk);
        for (int h = 0; h < 3; h++) begin
            chk($sformatf("bp_hold%0d_valid", h), int'(out_valid), 1);
            chk($sformatf("bp_hold%0d_d", h), int'(d_out), 65);
            chk($sformatf("bp_hold%0d_idx", h), int'(out_idx), 0);
            chk($sformatf("bp_hold%0d_busy", h), int'(busy), 1);
            if (h < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_valid%0d", k), int'(out_valid), 1);
            chk($sformatf("bp_y%0d", k), int'(d_out), exp_y(tbl[1], k));
            chk($sformatf("bp_idx%0d", k), int'(out_idx), k);
            @(negedge clk);
        end
        chk("bp_no_extra", int'(out_valid), 0);

        // streaming with in_valid held high
        s[0] = tbl[0];
        s[1] = tbl[1];
        s[2] = tbl[6];
        for (int v = 0; v < 3; v++)
            for (int k = 0; k < 4; k++) expq.push_back(exp_y(s[v], k));
        nres = 0;
        nacc = 0;
        last = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (nres < 12) begin
                    chk($sformatf("st_y%0d", nres), int'(d_out), expq[nres]);
                    chk($sformatf("st_idx%0d", nres), int'(out_idx), nres % 4);
                end
                nres++;
            end
            if (in_ready) begin
                if (nacc < 3) begin
                    if (nacc > 0) chk($sformatf("st_gap%0d", nacc), c - last, 5);
                    drive(s[nacc]);
                    in_valid = 1'b1;
                    last = c;
                    nacc++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                d_in_0    = 25'sd12345;
                d_in_1    = -25'sd777;
                d_in_2    = 25'sd999;
                d_in_3    = -25'sd4321;
                stage_sel = 1'b1;
            end
        end
        in_valid = 1'b0;
        chk("st_results", nres, 12);
        chk("st_accepts", nacc, 3);

        // reset while idx == 2
        send(tbl[1], "rs");
        @(negedge clk);
        chk("rs_y0", int'(d_out), 65);
        @(negedge clk);
        chk("rs_y1", int'(d_out), 28);
        chk("rs_idx1", int'(out_idx), 1);
        reset = 1'b0;
        #1;
        chk("rs_out_valid", int'(out_valid), 0);
        chk("rs_d_out", int'(d_out), 0);
        chk("rs_out_idx", int'(out_idx), 0);
        chk("rs_out_last", int'(out_last), 0);
        chk("rs_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        chk("rs_rel_in_ready", int'(in_ready), 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rs_quiet%0d", c), int'(out_valid), 0);
        end
        send(tbl[3], "rs_next");
        collect(tbl[3], "rs_next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
